frame_param_shadow: RTL and testbench

//  Frame-synchronous, double-buffered parameter register for the TX-side gaze/threshold path.

---
 rtl/frame_param_pkg.sv | 20 ++
 rtl/vsync_edge_sync.sv | 28 ++
 rtl/frame_param_shadow.sv | 125 ++++++++++++
 tb/tb_frame_param_shadow.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_param_pkg.sv
// Shared types and default widths for the frame-synchronous parameter shadow register.
package frame_param_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PENDING,
    S_COMMIT
  } state_e;

  localparam int unsigned GAZE_W_DEF  = 11;
  localparam int unsigned TRES_W_DEF  = 24;
  localparam int unsigned N_TRES_DEF  = 3;
  localparam int unsigned OVR_CNT_W   = 8;
  localparam int unsigned FRAME_CNT_W = 16;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (&v) ? v : v + OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Two-flop synchroniser for an asynchronous frame sync plus a one-cycle edge pulse
// when the synchronised level becomes POL.
module vsync_edge_sync #(
  parameter bit POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_edge = (sync_q == POL) && (prev_q != POL);

endmodule

// File: rtl/frame_param_shadow.sv
// Double-buffered gaze/threshold parameters committed atomically on the active VSYNC edge.
// Define PARAM_GAZE_CLAMP_EN to clamp staged gaze to the active raster at capture.
module frame_param_shadow
  import frame_param_pkg::*;
#(
  parameter int unsigned GAZE_W    = GAZE_W_DEF,
  parameter int unsigned TRES_W    = TRES_W_DEF,
  parameter int unsigned N_TRES    = N_TRES_DEF,
  parameter int unsigned H_ACTIVE  = 1920,
  parameter int unsigned V_ACTIVE  = 1080,
  parameter int unsigned VSYNC_POL = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_vsync,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic [GAZE_W-1:0]        i_wr_gaze_x,
  input  logic [GAZE_W-1:0]        i_wr_gaze_y,
  input  logic [N_TRES*TRES_W-1:0] i_wr_tres,
  output logic [GAZE_W-1:0]        o_gaze_x,
  output logic [GAZE_W-1:0]        o_gaze_y,
  output logic [N_TRES*TRES_W-1:0] o_tres,
  output logic                     o_update,
  output logic                     o_pending,
  output logic [OVR_CNT_W-1:0]     o_ovr_cnt,
  output logic [FRAME_CNT_W-1:0]   o_frame_cnt
);

`ifdef PARAM_GAZE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [GAZE_W-1:0] X_MAX = GAZE_W'(H_ACTIVE - 1);
  localparam logic [GAZE_W-1:0] Y_MAX = GAZE_W'(V_ACTIVE - 1);

  state_e                   state_q, state_d;
  logic                     vs_edge;
  logic                     accept;
  logic                     ready_q;
  logic [GAZE_W-1:0]        cap_x, cap_y;
  logic [GAZE_W-1:0]        stage_x_q, stage_y_q;
  logic [N_TRES*TRES_W-1:0] stage_tres_q;
  logic [GAZE_W-1:0]        gaze_x_q, gaze_y_q;
  logic [N_TRES*TRES_W-1:0] tres_q;
  logic                     update_q;
  logic [OVR_CNT_W-1:0]     ovr_q;
  logic [FRAME_CNT_W-1:0]   frame_q;

  vsync_edge_sync #(
    .POL (VSYNC_POL != 0)
  ) u_vsync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_vsync),
    .o_edge  (vs_edge)
  );

  // Writes are refused in the commit cycle so staging is stable while it is copied out.
  assign o_wr_ready = ready_q && (state_q != S_COMMIT);
  assign accept     = i_wr_valid && o_wr_ready;

  always_comb begin
    cap_x = i_wr_gaze_x;
    cap_y = i_wr_gaze_y;
    if (CLAMP_EN) begin
      if (i_wr_gaze_x > X_MAX) cap_x = X_MAX;
      if (i_wr_gaze_y > Y_MAX) cap_y = Y_MAX;
    end
  end

  // A write colliding with the edge in S_PENDING is captured first, so it becomes the commit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY:   if (accept) state_d = S_PENDING;
      S_PENDING: if (vs_edge) state_d = S_COMMIT;
      S_COMMIT:  state_d = S_EMPTY;
      default:   state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_EMPTY;
      ready_q      <= 1'b0;
      stage_x_q    <= '0;
      stage_y_q    <= '0;
      stage_tres_q <= '0;
      gaze_x_q     <= '0;
      gaze_y_q     <= '0;
      tres_q       <= '0;
      update_q     <= 1'b0;
      ovr_q        <= '0;
      frame_q      <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= 1'b1;
      update_q <= (state_q == S_COMMIT);
      if (accept) begin
        stage_x_q    <= cap_x;
        stage_y_q    <= cap_y;
        stage_tres_q <= i_wr_tres;
      end
      if (accept && (state_q == S_PENDING)) ovr_q <= sat_inc(ovr_q);
      if (state_q == S_COMMIT) begin
        gaze_x_q <= stage_x_q;
        gaze_y_q <= stage_y_q;
        tres_q   <= stage_tres_q;
      end
      if (vs_edge) frame_q <= frame_q + FRAME_CNT_W'(1);
    end
  end

  assign o_gaze_x    = gaze_x_q;
  assign o_gaze_y    = gaze_y_q;
  assign o_tres      = tres_q;
  assign o_update    = update_q;
  assign o_pending   = (state_q == S_PENDING);
  assign o_ovr_cnt   = ovr_q;
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_param_shadow.sv
// Directed bench for frame_param_shadow: reset, commit latency, overwrite, collisions, clamp.
module tb_frame_param_shadow;

  localparam int unsigned GW = 11;
  localparam int unsigned TW = 72;

  logic          clk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          wr_valid;
  logic          wr_ready;
  logic [GW-1:0] wr_x, wr_y;
  logic [TW-1:0] wr_tres;
  logic [GW-1:0] gaze_x, gaze_y;
  logic [TW-1:0] tres;
  logic          update, pending;
  logic [7:0]    ovr_cnt;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  frame_param_shadow dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_vsync     (vsync),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_gaze_x (wr_x),
    .i_wr_gaze_y (wr_y),
    .i_wr_tres   (wr_tres),
    .o_gaze_x    (gaze_x),
    .o_gaze_y    (gaze_y),
    .o_tres      (tres),
    .o_update    (update),
    .o_pending   (pending),
    .o_ovr_cnt   (ovr_cnt),
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one active edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] pack3(input int a0, input int a1, input int a2);
    return {24'(a2), 24'(a1), 24'(a0)};
  endfunction

  task automatic wr(input int x, input int y, input logic [TW-1:0] t);
    check("wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_x     = GW'(x);
    wr_y     = GW'(y);
    wr_tres  = t;
    step();
    wr_valid = 1'b0;
  endtask

  // Full vsync pulse: 4 cycles active, 4 idle; reports whether o_update was seen.
  task automatic vs_pulse(output bit seen);
    seen  = 1'b0;
    vsync = 1'b1;
    repeat (4) begin
      step();
      if (update) seen = 1'b1;
    end
    vsync = 1'b0;
    repeat (4) begin
      step();
      if (update) seen = 1'b1;
    end
  endtask

  bit seen;
  int exp_cx, exp_cy;

  initial begin
    rst      = 1'b1;
    vsync    = 1'b0;
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_tres  = '0;

    // Reset
    repeat (3) step();
    check("rst_ready", wr_ready, 1'b0);
    check("rst_gx", gaze_x, 0);
    check("rst_gy", gaze_y, 0);
    check("rst_tres", tres, 0);
    check("rst_update", update, 0);
    check("rst_pending", pending, 0);
    check("rst_ovr", ovr_cnt, 0);
    check("rst_frame", frame_cnt, 0);
    rst = 1'b0;
    step();
    check("post_rst_ready", wr_ready, 1'b1);

    // Basic commit with k+3 latency
    wr(100, 50, pack3(1, 2, 3));
    check("basic_pending", pending, 1'b1);
    vsync = 1'b1;
    step();                               // edge k
    step();                               // k+1
    step();                               // k+2: commit state
    check("basic_k2_update", update, 1'b0);
    check("basic_k2_gx", gaze_x, 0);
    check("basic_k2_ready", wr_ready, 1'b0);
    step();                               // k+3
    check("basic_k3_update", update, 1'b1);
    check("basic_gx", gaze_x, 100);
    check("basic_gy", gaze_y, 50);
    check("basic_tres", tres, 72'h000003_000002_000001);
    check("basic_pending_clr", pending, 1'b0);
    step();
    check("basic_update_pulse", update, 1'b0);
    check("basic_frame", frame_cnt, 1);
    vsync = 1'b0;
    repeat (4) step();

    // No pending: two frames, nothing commits
    vs_pulse(seen);
    check("nopend_update1", seen, 1'b0);
    vs_pulse(seen);
    check("nopend_update2", seen, 1'b0);
    check("nopend_gx", gaze_x, 100);
    check("nopend_frame", frame_cnt, 3);

    // Overwrite: last write wins
    wr(1, 5, pack3(4, 5, 6));
    wr(2, 5, pack3(4, 5, 6));
    wr(3, 6, pack3(7, 8, 9));
    check("ovr_cnt2", ovr_cnt, 2);
    vs_pulse(seen);
    check("ovr_update", seen, 1'b1);
    check("ovr_gx", gaze_x, 3);
    check("ovr_gy", gaze_y, 6);
    check("ovr_tres", tres, 72'h000009_000008_000007);
    check("ovr_frame", frame_cnt, 4);

    // Collision in S_PENDING: write coincides with edge pulse
    wr(5, 1, pack3(1, 1, 1));
    vsync = 1'b1;
    step();                               // k
    step();                               // k+1: edge pulse visible this cycle
    wr(7, 2, pack3(2, 2, 2));             // captured at k+2
    check("coll_ready_commit", wr_ready, 1'b0);
    step();                               // k+3
    check("coll_update", update, 1'b1);
    check("coll_gx", gaze_x, 7);
    check("coll_gy", gaze_y, 2);
    check("coll_ovr", ovr_cnt, 3);
    check("coll_frame", frame_cnt, 5);
    vsync = 1'b0;
    repeat (4) step();

    // Collision in S_EMPTY: staged, waits for the next frame
    vsync = 1'b1;
    step();
    step();
    wr(9, 4, pack3(3, 3, 3));
    check("empty_coll_pending", pending, 1'b1);
    step();
    check("empty_coll_no_update", update, 1'b0);
    check("empty_coll_gx_hold", gaze_x, 7);
    vsync = 1'b0;
    repeat (4) step();
    vs_pulse(seen);
    check("empty_coll_commit", seen, 1'b1);
    check("empty_coll_gx", gaze_x, 9);
    check("empty_coll_ovr", ovr_cnt, 3);
    check("empty_coll_frame", frame_cnt, 7);

    // Clamp boundary
`ifdef PARAM_GAZE_CLAMP_EN
    exp_cx = 1919;
    exp_cy = 1079;
`else
    exp_cx = 2047;
    exp_cy = 2047;
`endif
    wr(2047, 2047, pack3(16777215, 0, 1));
    vs_pulse(seen);
    check("clamp_gx", gaze_x, exp_cx);
    check("clamp_gy", gaze_y, exp_cy);
    check("clamp_tres", tres, 72'h000001_000000_ffffff);

    // Reset mid-frame with a pending set
    wr(11, 12, pack3(5, 5, 5));
    vsync = 1'b1;
    step();
    rst   = 1'b1;
    vsync = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_gx", gaze_x, 0);
    check("mid_rst_tres", tres, 0);
    check("mid_rst_pending", pending, 0);
    check("mid_rst_ovr", ovr_cnt, 0);
    check("mid_rst_frame", frame_cnt, 0);
    repeat (4) step();
    check("mid_rst_frame_hold", frame_cnt, 0);
    check("mid_rst_update", update, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
